// File: rtl/effect_sequencer.sv
// effect_sequencer: round-robin effect scheduler with per-effect dwell, speed scaling, pause and skip
module effect_sequencer #(
   parameter int N_EFF    = 7,
   parameter int TICK_DIV = 500000,
   parameter int DWELL_W  = 16,
   parameter logic [N_EFF*DWELL_W-1:0] DWELL =
      {16'd6800, 16'd6600, 16'd3200, 16'd2200, 16'd1400, 16'd1400, 16'd4800}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             next_pulse,
   input  logic             speed_pulse,
   input  logic             pause_pulse,
   input  logic [N_EFF-1:0] enable_mask,
   output logic [2:0]       effect_sel,
   output logic [N_EFF-1:0] effect_onehot_n,
   output logic             effect_start,
   output logic [1:0]       speed,
   output logic             paused,
   output logic             idle
);
   localparam int PW = $clog2(TICK_DIV);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
   state_t             state_q;
   logic [PW-1:0]      presc_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [2:0]         sel_q;
   logic [N_EFF-1:0]   onehot_q;
   logic               start_q;
   logic [1:0]         speed_q;
   logic               paused_q;
   logic               idle_q;
   logic [2:0]         lowest;
   logic [2:0]         nxt;
   logic               found;
   logic [DWELL_W-1:0] entry;
   logic [DWELL_W-1:0] shifted;
   logic [DWELL_W-1:0] target;
   logic               tick;
   logic               expire;
   logic [1:0]         speed_d;
   // lowest enabled index, next enabled index after current, and dwell expiry for the current effect
   always_comb begin
      lowest = '0;
      for (int i = N_EFF - 1; i >= 0; i--)
         if (enable_mask[i]) lowest = 3'(i);
      nxt   = sel_q;
      found = 1'b0;
      for (int k = 1; k <= N_EFF; k++)
         if (!found && enable_mask[(int'(sel_q) + k) % N_EFF]) begin
            nxt   = 3'((int'(sel_q) + k) % N_EFF);
            found = 1'b1;
         end
      entry   = DWELL[int'(sel_q)*DWELL_W +: DWELL_W];
      shifted = entry >> speed_q;
      target  = (shifted == '0) ? DWELL_W'(1) : shifted;
      tick    = !paused_q && (presc_q == PW'(TICK_DIV - 1));
      expire  = tick && (({1'b0, dwell_q} + (DWELL_W+1)'(1)) >= {1'b0, target});
      speed_d = speed_pulse ? speed_q + 2'd1 : speed_q;
   end
   // sequencer FSM with registered outputs; mode overrides everything but reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         onehot_q <= '1;
         start_q  <= 1'b0;
         speed_q  <= '0;
         paused_q <= 1'b0;
         idle_q   <= 1'b1;
         presc_q  <= '0;
         dwell_q  <= '0;
      end else if (mode) begin
         state_q  <= S_HOLD;
         onehot_q <= '1;
         start_q  <= 1'b0;
         speed_q  <= '0;
         paused_q <= 1'b0;
         idle_q   <= 1'b1;
         presc_q  <= '0;
         dwell_q  <= '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               state_q <= S_IDLE;
               start_q <= 1'b0;
            end
            S_IDLE: begin
               speed_q <= speed_d;
               start_q <= |enable_mask;
               if (|enable_mask) begin
                  state_q  <= S_RUN;
                  sel_q    <= lowest;
                  onehot_q <= ~(N_EFF'(1) << lowest);
                  idle_q   <= 1'b0;
                  presc_q  <= '0;
                  dwell_q  <= '0;
               end
            end
            default: begin
               speed_q  <= speed_d;
               paused_q <= paused_q ^ pause_pulse;
               start_q  <= 1'b0;
               if (enable_mask == '0) begin
                  state_q  <= S_IDLE;
                  onehot_q <= '1;
                  idle_q   <= 1'b1;
               end else if (next_pulse || !enable_mask[sel_q] || expire) begin
                  sel_q    <= nxt;
                  onehot_q <= ~(N_EFF'(1) << nxt);
                  start_q  <= 1'b1;
                  presc_q  <= '0;
                  dwell_q  <= '0;
               end else if (!paused_q) begin
                  presc_q <= tick ? '0 : presc_q + PW'(1);
                  dwell_q <= dwell_q + DWELL_W'(tick);
               end
            end
         endcase
      end
   end
   assign effect_sel      = sel_q;
   assign effect_onehot_n = onehot_q;
   assign effect_start    = start_q;
   assign speed           = speed_q;
   assign paused          = paused_q;
   assign idle            = idle_q;
endmodule

// File: tb/tb_effect_sequencer.sv
// tb_effect_sequencer: directed scenarios plus random stimulus against a cycle-count reference model
module tb_effect_sequencer;
   localparam int N  = 7;
   localparam int TD = 4;
   localparam logic [N*16-1:0] DW = {16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd4, 16'd8};
   int dw_tbl[N] = '{8, 4, 4, 6, 8, 10, 12};
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       next_pulse = 1'b0;
   logic       speed_pulse = 1'b0;
   logic       pause_pulse = 1'b0;
   logic [6:0] enable_mask = '0;
   logic [2:0] effect_sel;
   logic [6:0] effect_onehot_n;
   logic       effect_start;
   logic [1:0] speed;
   logic       paused;
   logic       idle;
   int n_chk = 0;
   int n_err = 0;
   int m_state = 0;
   int m_sel = 0;
   int m_el = 0;
   int m_speed = 0;
   int m_start = 0;
   int m_paused = 0;

   effect_sequencer #(.N_EFF(N), .TICK_DIV(TD), .DWELL_W(16), .DWELL(DW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .next_pulse(next_pulse), .speed_pulse(speed_pulse),
      .pause_pulse(pause_pulse), .enable_mask(enable_mask), .effect_sel(effect_sel),
      .effect_onehot_n(effect_onehot_n), .effect_start(effect_start), .speed(speed),
      .paused(paused), .idle(idle));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest_of(input logic [6:0] m);
      for (int i = 0; i < N; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int after(input int s, input logic [6:0] m);
      for (int k = 1; k <= N; k++) if (m[(s + k) % N]) return (s + k) % N;
      return s;
   endfunction

   // model: m_el counts unpaused clocks spent in the current effect; 0 idle, 1 run, 2 hold
   task automatic model_update();
      int tgt;
      bit ex;
      if (rst) begin
         m_state = 0; m_sel = 0; m_el = 0; m_speed = 0; m_start = 0; m_paused = 0;
      end else if (mode) begin
         m_state = 2; m_el = 0; m_speed = 0; m_start = 0; m_paused = 0;
      end else if (m_state == 2) begin
         m_state = 0; m_start = 0;
      end else if (m_state == 0) begin
         m_start = 0;
         if (speed_pulse) m_speed = (m_speed + 1) % 4;
         if (enable_mask != 0) begin
            m_sel = lowest_of(enable_mask); m_start = 1; m_el = 0; m_state = 1;
         end
      end else begin
         m_start = 0;
         tgt = dw_tbl[m_sel] >> m_speed;
         if (tgt < 1) tgt = 1;
         ex = !m_paused && ((m_el + 1) % TD == 0) && ((m_el + 1) / TD >= tgt);
         if (enable_mask == 0) m_state = 0;
         else if (next_pulse || !enable_mask[m_sel] || ex) begin
            m_sel = after(m_sel, enable_mask); m_el = 0; m_start = 1;
         end else if (!m_paused) m_el++;
         if (speed_pulse) m_speed = (m_speed + 1) % 4;
         if (pause_pulse) m_paused = !m_paused;
      end
   endtask

   task automatic compare_all();
      logic [6:0] e;
      e = (m_state == 1) ? ~(7'b1 << m_sel) : 7'h7F;
      check("sel", 32'(effect_sel), 32'(m_sel));
      check("onehot_n", 32'(effect_onehot_n), 32'(e));
      check("start", 32'(effect_start), 32'(m_start));
      check("speed", 32'(speed), 32'(m_speed));
      check("paused", 32'(paused), 32'(m_paused));
      check("idle", 32'(idle), 32'(m_state != 1));
   endtask

   task automatic step(input bit nx = 0, input bit sp = 0, input bit pp = 0);
      @(negedge clk);
      next_pulse = nx; speed_pulse = sp; pause_pulse = pp;
      @(posedge clk);
      model_update();
      #1 compare_all();
   endtask

   initial begin
      int seq[3] = '{4, 6, 1};
      int dwl[3] = '{4, 8, 12};
      step();
      check("rst_sel", 32'(effect_sel), 0);
      check("rst_onehot", 32'(effect_onehot_n), 32'h7F);
      check("rst_start", 32'(effect_start), 0);
      check("rst_speed", 32'(speed), 0);
      check("rst_paused", 32'(paused), 0);
      check("rst_idle", 32'(idle), 1);
      rst = 0; enable_mask = 7'h7F;
      step();
      check("t1_start", 32'(effect_start), 1);
      check("t1_sel0", 32'(effect_sel), 0);
      check("t1_onehot", 32'(effect_onehot_n), 32'b1111110);
      repeat (31) step();
      check("t1_hold", 32'(effect_sel), 0);
      step();
      check("t1_sel1", 32'(effect_sel), 1);
      check("t1_start1", 32'(effect_start), 1);
      enable_mask = 7'b1010010;
      for (int j = 0; j < 3; j++) begin
         repeat (dwl[j] * TD - 1) step();
         check("t2_dwell", 32'(effect_start), 0);
         step();
         check("t2_sel", 32'(effect_sel), 32'(seq[j]));
         check("t2_start", 32'(effect_start), 1);
      end
      step(0, 1); step(0, 1);
      check("t3_speed2", 32'(speed), 2);
      enable_mask = 7'b0000001;
      step();
      check("t3_sel0", 32'(effect_sel), 0);
      repeat (7) step();
      check("t3_wait", 32'(effect_start), 0);
      step();
      check("t3_reselect", 32'(effect_start), 1);
      step(0, 1); step(0, 1);
      check("t3_wrap", 32'(speed), 0);
      enable_mask = 7'h7F;
      repeat (5) step();
      step(0, 0, 1);
      check("t4_paused", 32'(paused), 1);
      repeat (100) step();
      check("t4_frozen", 32'(effect_sel), 0);
      step(1);
      check("t4_skip", 32'(effect_sel), 1);
      check("t4_still_paused", 32'(paused), 1);
      step(0, 0, 1);
      enable_mask = 7'h7D;
      step();
      check("t5_disable", 32'(effect_sel), 2);
      check("t5_start", 32'(effect_start), 1);
      enable_mask = 7'h00;
      step();
      check("t5_idle", 32'(idle), 1);
      check("t5_onehot", 32'(effect_onehot_n), 32'h7F);
      repeat (10) begin
         step();
         check("t5_nostart", 32'(effect_start), 0);
      end
      enable_mask = 7'h7F;
      step();
      step(0, 1);
      check("t6_speed1", 32'(speed), 1);
      mode = 1;
      step();
      check("t6_idle", 32'(idle), 1);
      check("t6_speed0", 32'(speed), 0);
      mode = 0; enable_mask = 7'b0001000;
      step();
      step();
      check("t6_sel3", 32'(effect_sel), 3);
      check("t6_start", 32'(effect_start), 1);
      repeat (4000) begin
         if ($urandom_range(0, 299) == 0)
            enable_mask = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
         if (mode) mode = ($urandom_range(0, 39) != 0);
         else mode = ($urandom_range(0, 799) == 0);
         rst = ($urandom_range(0, 1999) == 0);
         step($urandom_range(0, 79) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 149) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
